// File: rtl/jamma_joy_scan.sv
// Time-multiplexed JAMMA joystick scanner with per-player debounce.
// Optional macro JOY_DEBOUNCE_EN enables the debounce filter.
module jamma_joy_scan #(
  parameter int PLAYERS = 2,
  parameter int WIDTH   = 8,
  parameter int DIV     = 32,
  parameter int SETTLE  = 1,
  parameter int DEB     = 3,
  localparam int SEL_W  = (PLAYERS > 2) ? $clog2(PLAYERS) : 1
) (
  input  logic                       clk_sys,
  input  logic                       reset_n,
  input  logic [WIDTH-1:0]           jjoy_in,
  input  logic [WIDTH-1:0]           local_in,
  output logic [SEL_W-1:0]           jselect,
  output logic [PLAYERS*WIDTH-1:0]   joy_out,
  output logic                       scan_done
);

  localparam int CW = $clog2(DIV);
  localparam int SW = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {
    S_SETTLE,
    S_SAMPLE,
    S_ADVANCE
  } state_e;

  // Reject parameter sets the scanner cannot honour
  if (PLAYERS < 2 || PLAYERS > 4) begin : g_bad_players
    $error("jamma_joy_scan: PLAYERS out of range");
  end
  if (DIV < 4) begin : g_bad_div
    $error("jamma_joy_scan: DIV too small");
  end
  if (SETTLE < 1) begin : g_bad_settle
    $error("jamma_joy_scan: SETTLE too small");
  end
  if (DEB < 1 || DEB > 15) begin : g_bad_deb
    $error("jamma_joy_scan: DEB out of range");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             done_q, done_d;
  logic             tick;
  logic             last_ch;
  logic             samp_en;

  logic [WIDTH-1:0] jj_s1_q, jj_s2_q;
  logic [WIDTH-1:0] lc_s1_q, lc_s2_q;
  logic [WIDTH-1:0] samp;
  logic [WIDTH-1:0] joy_q [PLAYERS];

  // Two-flop synchronisers for the asynchronous connector and local pad
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      jj_s1_q <= '1;
      jj_s2_q <= '1;
      lc_s1_q <= '1;
      lc_s2_q <= '1;
    end else begin
      jj_s1_q <= jjoy_in;
      jj_s2_q <= jj_s1_q;
      lc_s1_q <= local_in;
      lc_s2_q <= lc_s1_q;
    end
  end

  assign samp    = jj_s2_q & ((ch_q == '0) ? lc_s2_q : '1);
  assign tick    = (cnt_q == CW'(DIV - 1));
  assign cnt_d   = tick ? '0 : cnt_q + 1'b1;
  assign last_ch = (ch_q == SEL_W'(PLAYERS - 1));

  // Free-running tick prescaler
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  // Scan FSM state and select registers
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_SETTLE;
      settle_q <= SW'(SETTLE);
      ch_q     <= '0;
      sel_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      ch_q     <= ch_d;
      sel_q    <= sel_d;
      done_q   <= done_d;
    end
  end

  // Next-state: settle, one sample cycle, then step to the next player
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    ch_d     = ch_q;
    sel_d    = sel_q;
    done_d   = 1'b0;
    samp_en  = 1'b0;
    unique case (state_q)
      S_SETTLE: begin
        if (tick) begin
          if (settle_q == '0) state_d = S_SAMPLE;
          else                settle_d = settle_q - 1'b1;
        end
      end
      S_SAMPLE: begin
        samp_en = 1'b1;
        state_d = S_ADVANCE;
      end
      S_ADVANCE: begin
        ch_d     = last_ch ? '0 : ch_q + 1'b1;
        sel_d    = ch_d;
        done_d   = last_ch;
        settle_d = SW'(SETTLE);
        state_d  = S_SETTLE;
      end
      default: state_d = S_SETTLE;
    endcase
  end

`ifdef JOY_DEBOUNCE_EN
  logic [WIDTH-1:0] last_q [PLAYERS];
  logic [3:0]       stab_q [PLAYERS];
  logic [3:0]       stab_d;

  // Stability count for the current player after this sample
  always_comb begin
    stab_d = 4'd1;
    if (samp == last_q[ch_q]) begin
      if (stab_q[ch_q] >= 4'(DEB)) stab_d = 4'(DEB);
      else                         stab_d = stab_q[ch_q] + 4'd1;
    end
  end

  // Debounce state; only the scanned player's entries move
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < PLAYERS; p++) begin
        last_q[p] <= '1;
        stab_q[p] <= '0;
        joy_q[p]  <= '1;
      end
    end else if (samp_en) begin
      last_q[ch_q] <= samp;
      stab_q[ch_q] <= stab_d;
      if (stab_d == 4'(DEB)) joy_q[ch_q] <= samp;
    end
  end
`else
  // Without debounce each sample lands directly on the output
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < PLAYERS; p++) joy_q[p] <= '1;
    end else if (samp_en) begin
      joy_q[ch_q] <= samp;
    end
  end
`endif

  for (genvar g = 0; g < PLAYERS; g++) begin : g_out
    assign joy_out[g*WIDTH +: WIDTH] = joy_q[g];
  end

  assign jselect   = sel_q;
  assign scan_done = done_q;

endmodule

// File: tb/tb_jamma_joy_scan.sv
// Directed bench for jamma_joy_scan (2 players, DIV=4, SETTLE=1, DEB=3).
// Expectations follow JOY_DEBOUNCE_EN as compiled.
`timescale 1ns/1ps
module tb_jamma_joy_scan;

`ifdef JOY_DEBOUNCE_EN
  localparam bit DEB_ON = 1'b1;
`else
  localparam bit DEB_ON = 1'b0;
`endif

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  p0 = 8'hFF;
  logic [7:0]  p1 = 8'hFF;
  logic [7:0]  local_in = 8'hFF;
  logic [7:0]  jjoy_in;
  logic [0:0]  jselect;
  logic [15:0] joy_out;
  logic        scan_done;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  int cyc      = 0;

  jamma_joy_scan #(
    .PLAYERS(2),
    .WIDTH(8),
    .DIV(4),
    .SETTLE(1),
    .DEB(3)
  ) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .jjoy_in(jjoy_in),
    .local_in(local_in),
    .jselect(jselect),
    .joy_out(joy_out),
    .scan_done(scan_done)
  );

  // Connector model: the selected player drives the shared bus
  assign jjoy_in = jselect[0] ? p1 : p0;

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic wait_sel(input logic v);
    int n;
    n = 0;
    do begin
      @(negedge clk_sys);
      n++;
    end while (jselect[0] !== v && n < 200);
    if (jselect[0] !== v) begin
      tot_cnt++;
      $display("FAIL wait_sel timeout got %b want %b", jselect, v);
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk_sys);
      n++;
    end while (scan_done !== 1'b1 && n < 200);
    if (scan_done !== 1'b1) begin
      tot_cnt++;
      $display("FAIL wait_done timeout");
    end
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    reset_n = 1'b0;
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    p0 = 8'hFF; p1 = 8'hFF; local_in = 8'hFF;
    reset_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    tot_cnt++;
    if (joy_out !== 16'hFFFF)
      $display("FAIL reset_joy got %h want ffff", joy_out);
    else pass_cnt++;
    tot_cnt++;
    if (jselect !== 1'b0)
      $display("FAIL reset_sel got %b want 0", jselect);
    else pass_cnt++;
    tot_cnt++;
    if (scan_done !== 1'b0)
      $display("FAIL reset_done got %b want 0", scan_done);
    else pass_cnt++;
  endtask

  task automatic test_free_run();
    int t1, t2, t3, t4, hi, wide;
    logic prev;
    p0 = 8'hFF; p1 = 8'hFF; local_in = 8'hFF;
    do_reset();
    wait_sel(1'b1); t1 = cyc;
    wait_sel(1'b0); t2 = cyc;
    tot_cnt++;
    if (t2 - t1 != 8)
      $display("FAIL slot0_period got %0d want 8", t2 - t1);
    else pass_cnt++;
    tot_cnt++;
    if (scan_done !== 1'b1)
      $display("FAIL done_at_wrap got %b want 1", scan_done);
    else pass_cnt++;
    @(negedge clk_sys);
    tot_cnt++;
    if (scan_done !== 1'b0)
      $display("FAIL done_width got %b want 0", scan_done);
    else pass_cnt++;
    wait_sel(1'b1); t3 = cyc;
    wait_sel(1'b0); t4 = cyc;
    tot_cnt++;
    if (t3 - t2 != 8 || t4 - t3 != 8)
      $display("FAIL slot_period got %0d/%0d want 8/8", t3 - t2, t4 - t3);
    else pass_cnt++;
    hi = 0; wide = 0; prev = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk_sys);
      if (scan_done === 1'b1) hi++;
      if (scan_done === 1'b1 && prev === 1'b1) wide++;
      prev = scan_done;
    end
    tot_cnt++;
    if (hi != 4)
      $display("FAIL done_count got %0d want 4", hi);
    else pass_cnt++;
    tot_cnt++;
    if (wide != 0)
      $display("FAIL done_wide got %0d want 0", wide);
    else pass_cnt++;
  endtask

  task automatic test_debounce_commit();
    logic [7:0] exp;
    p0 = 8'hFF; p1 = 8'hFE; local_in = 8'hFF;
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      wait_done();
      exp = (DEB_ON && k < 3) ? 8'hFF : 8'hFE;
      tot_cnt++;
      if (joy_out[15:8] !== exp)
        $display("FAIL commit_p1_scan%0d got %h want %h", k, joy_out[15:8], exp);
      else pass_cnt++;
      tot_cnt++;
      if (joy_out[7:0] !== 8'hFF)
        $display("FAIL commit_p0_scan%0d got %h want ff", k, joy_out[7:0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_glitch();
    logic [7:0] exp;
    p0 = 8'hFF; p1 = 8'hFE; local_in = 8'hFF;
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      wait_done();
      p1 = 8'hFF;
      exp = (!DEB_ON && k == 1) ? 8'hFE : 8'hFF;
      tot_cnt++;
      if (joy_out[15:8] !== exp)
        $display("FAIL glitch_scan%0d got %h want %h", k, joy_out[15:8], exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_local_and_reset();
    int r;
    p0 = 8'hFF; p1 = 8'hFF; local_in = 8'hEF;
    do_reset();
    repeat (3) wait_done();
    tot_cnt++;
    if (joy_out[7:0] !== 8'hEF)
      $display("FAIL local_p0 got %h want ef", joy_out[7:0]);
    else pass_cnt++;
    tot_cnt++;
    if (joy_out[15:8] !== 8'hFF)
      $display("FAIL local_p1 got %h want ff", joy_out[15:8]);
    else pass_cnt++;
    wait_sel(1'b1);
    @(negedge clk_sys);
    reset_n = 1'b0;
    #1;
    tot_cnt++;
    if (jselect !== 1'b0)
      $display("FAIL midrst_sel got %b want 0", jselect);
    else pass_cnt++;
    tot_cnt++;
    if (joy_out !== 16'hFFFF)
      $display("FAIL midrst_joy got %h want ffff", joy_out);
    else pass_cnt++;
    @(negedge clk_sys);
    reset_n = 1'b1;
    r = cyc;
    wait_sel(1'b1);
    tot_cnt++;
    if (cyc - r != 10)
      $display("FAIL restart_delay got %0d want 10", cyc - r);
    else pass_cnt++;
  endtask

  task automatic test_sample_timing();
    p0 = 8'hFF; p1 = 8'h7F; local_in = 8'hFF;
    do_reset();
    wait_sel(1'b1);
    repeat (6) @(negedge clk_sys);
    tot_cnt++;
    if (joy_out[15:8] !== 8'hFF)
      $display("FAIL pre_sample got %h want ff", joy_out[15:8]);
    else pass_cnt++;
    @(negedge clk_sys);
    tot_cnt++;
    if (joy_out[15:8] !== (DEB_ON ? 8'hFF : 8'h7F))
      $display("FAIL post_sample got %h want %h", joy_out[15:8],
               DEB_ON ? 8'hFF : 8'h7F);
    else pass_cnt++;
    repeat (3) wait_done();
    tot_cnt++;
    if (joy_out[15:8] !== 8'h7F)
      $display("FAIL settled_p1 got %h want 7f", joy_out[15:8]);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_debounce_commit();
    test_glitch();
    test_local_and_reset();
    test_sample_timing();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
